// File: rtl/alu_exec_sequencer.sv
// Operand/control sequencer feeding an 8-bit combinational ALU: IDLE -> EXEC -> WB.
// Optional retire counter output enabled by defining SEQ_RETIRE_CNT_EN.
module alu_exec_sequencer #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned IMM_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_op,
  input  logic [1:0]       instr_rd,
  input  logic [1:0]       instr_rs1,
  input  logic [1:0]       instr_rs2,
  input  logic [IMM_W-1:0] instr_imm,
  input  logic             ld_en,
  input  logic [1:0]       ld_addr,
  input  logic [7:0]       ld_data,
  input  logic [1:0]       rd_addr,
  output logic [7:0]       rd_data,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [7:0]       alu_f,
  input  logic             alu_ovf,
  input  logic             alu_take_branch,
  output logic             wb_valid,
  output logic [1:0]       wb_rd,
  output logic [7:0]       wb_data,
  output logic [PC_W-1:0]  pc,
  output logic             ovf_sticky,
  input  logic             clr_ovf,
`ifdef SEQ_RETIRE_CNT_EN
  output logic [15:0]      retire_cnt,
`endif
  output logic             busy
);

  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

  state_t state, state_nx;

  logic [DW-1:0]    regs [NREG];
  logic [2:0]       op_q;
  logic [1:0]       rd_q, rs1_q, rs2_q;
  logic [IMM_W-1:0] imm_q;
  logic [DW-1:0]    f_q;
  logic             ovf_q, tb_q;

  logic             accept, is_branch, set_ovf;
  logic [PC_W-1:0]  imm_sext, pc_nx;

  assign accept    = instr_valid & instr_ready;
  assign is_branch = op_q[2] & op_q[1];
  assign set_ovf   = (state == WB) && (op_q == 3'b000) && ovf_q;
  assign imm_sext  = {{(PC_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
  assign pc_nx     = (is_branch && tb_q) ? pc + imm_sext : pc + PC_W'(1);
  assign rd_data   = regs[rd_addr];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State-decoded outputs; ALU inputs only driven during EXEC
  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b1;
    alu_a       = '0;
    alu_b       = '0;
    alu_sel     = '0;
    case (state)
      IDLE: begin
        busy        = 1'b0;
        instr_ready = ~ld_en;
      end
      EXEC: begin
        alu_a   = regs[rs1_q];
        alu_b   = regs[rs2_q];
        alu_sel = op_q;
      end
      default: ;
    endcase
  end

  // Datapath: register file, instruction latches, ALU capture, writeback, PC
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      f_q        <= '0;
      ovf_q      <= 1'b0;
      tb_q       <= 1'b0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      pc         <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_en) begin
            regs[ld_addr] <= ld_data;
          end else if (accept) begin
            op_q  <= instr_op;
            rd_q  <= instr_rd;
            rs1_q <= instr_rs1;
            rs2_q <= instr_rs2;
            imm_q <= instr_imm;
          end
        end
        EXEC: begin
          f_q   <= alu_f;
          ovf_q <= alu_ovf;
          tb_q  <= alu_take_branch;
          // wb_* is registered here so it is visible throughout the WB cycle
          if (!is_branch) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= alu_f;
          end
        end
        WB: begin
          if (!is_branch) regs[rd_q] <= f_q;
          pc <= pc_nx;
        end
        default: ;
      endcase
      if (set_ovf)      ovf_sticky <= 1'b1;
      else if (clr_ovf) ovf_sticky <= 1'b0;
    end
  end

`ifdef SEQ_RETIRE_CNT_EN
  // Counts every retirement, writebacks and branches alike
  always_ff @(posedge clk) begin
    if (rst)              retire_cnt <= '0;
    else if (state == WB) retire_cnt <= retire_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Scoreboard bench for alu_exec_sequencer with a behavioural ALU model attached.
module tb_alu_exec_sequencer;

  localparam int unsigned PC_W  = 8;
  localparam int unsigned IMM_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             instr_valid = 1'b0;
  logic             instr_ready;
  logic [2:0]       instr_op = '0;
  logic [1:0]       instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic [IMM_W-1:0] instr_imm = '0;
  logic             ld_en = 1'b0;
  logic [1:0]       ld_addr = '0;
  logic [7:0]       ld_data = '0;
  logic [1:0]       rd_addr = '0;
  logic [7:0]       rd_data;
  logic [7:0]       alu_a, alu_b;
  logic [2:0]       alu_sel;
  logic [7:0]       alu_f;
  logic             alu_ovf, alu_take_branch;
  logic             wb_valid;
  logic [1:0]       wb_rd;
  logic [7:0]       wb_data;
  logic [PC_W-1:0]  pc;
  logic             ovf_sticky;
  logic             clr_ovf = 1'b0;
  logic             busy;
`ifdef SEQ_RETIRE_CNT_EN
  logic [15:0]      retire_cnt;
`endif

  always #5 clk = ~clk;

  alu_exec_sequencer #(.PC_W(PC_W), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_f(alu_f), .alu_ovf(alu_ovf), .alu_take_branch(alu_take_branch),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .pc(pc), .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf),
`ifdef SEQ_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .busy(busy)
  );

  // Behavioural ALU: add, sub, and, or, xor, not, beq, bne
  logic [7:0] add_r, sub_r;
  assign add_r = alu_a + alu_b;
  assign sub_r = alu_a - alu_b;
  always_comb begin
    alu_f = '0;
    alu_ovf = 1'b0;
    alu_take_branch = 1'b0;
    case (alu_sel)
      3'd0: begin alu_f = add_r; alu_ovf = (alu_a[7] == alu_b[7]) && (add_r[7] != alu_a[7]); end
      3'd1: begin alu_f = sub_r; alu_ovf = (alu_a[7] != alu_b[7]) && (sub_r[7] != alu_a[7]); end
      3'd2: alu_f = alu_a & alu_b;
      3'd3: alu_f = alu_a | alu_b;
      3'd4: alu_f = alu_a ^ alu_b;
      3'd5: alu_f = ~alu_a;
      3'd6: alu_take_branch = (alu_a == alu_b);
      default: alu_take_branch = (alu_a != alu_b);
    endcase
  end

  int passed = 0;
  int total  = 0;

  typedef struct { logic [1:0] rd; logic [7:0] data; } wb_t;
  typedef struct { logic [7:0] pc; logic ovf; } ret_t;
  wb_t  wb_q[$];
  ret_t ret_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: compares writebacks and retirements against the expected queues
  logic prev_busy = 1'b0;
  logic prev_rst  = 1'b1;
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      check("wb_expected", 32'(wb_q.size() != 0), 32'd1);
      if (wb_q.size() != 0) begin
        check("wb_rd", 32'(wb_rd), 32'(wb_q[0].rd));
        check("wb_data", 32'(wb_data), 32'(wb_q[0].data));
        void'(wb_q.pop_front());
      end
    end
    if (prev_busy === 1'b1 && busy === 1'b0 && prev_rst === 1'b0) begin
      check("retire_expected", 32'(ret_q.size() != 0), 32'd1);
      if (ret_q.size() != 0) begin
        check("retire_pc", 32'(pc), 32'(ret_q[0].pc));
        check("retire_ovf", 32'(ovf_sticky), 32'(ret_q[0].ovf));
        void'(ret_q.pop_front());
      end
    end
    prev_busy <= busy;
    prev_rst  <= rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [1:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic push_wb(input logic [1:0] rd, input logic [7:0] d);
    wb_t w;
    w.rd = rd; w.data = d;
    wb_q.push_back(w);
  endtask

  task automatic push_ret(input logic [7:0] p, input logic o);
    ret_t r;
    r.pc = p; r.ovf = o;
    ret_q.push_back(r);
  endtask

  // One instruction end to end; checks ALU drive and the two-cycle ready gap
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [3:0] imm,
                       input logic [7:0] ea, input logic [7:0] eb, input logic clr_in_wb);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd;
    instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    tick();
    instr_valid = 1'b0;
    check("exec_alu_a", 32'(alu_a), 32'(ea));
    check("exec_alu_b", 32'(alu_b), 32'(eb));
    check("exec_alu_sel", 32'(alu_sel), 32'(op));
    check("exec_ready", 32'(instr_ready), 32'd0);
    if (clr_in_wb) clr_ovf = 1'b1;
    tick();
    check("wb_ready", 32'(instr_ready), 32'd0);
    check("wb_alu_a_zero", 32'(alu_a), 32'd0);
    tick();
    clr_ovf = 1'b0;
    check("idle_ready", 32'(instr_ready), 32'd1);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_ovf", 32'(ovf_sticky), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(instr_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      check("rst_reg", 32'(rd_data), 32'd0);
    end

    // Signed-overflowing add
    ld(2'd1, 8'h70); ld(2'd2, 8'h20);
    push_wb(2'd3, 8'h90); push_ret(8'd1, 1'b1);
    issue(3'b000, 2'd3, 2'd1, 2'd2, 4'h0, 8'h70, 8'h20, 1'b0);
    rd_addr = 2'd3; #1;
    check("rd_r3", 32'(rd_data), 32'h90);

    // AND, then or / xor / add to walk pc to 5
    ld(2'd0, 8'hF0); ld(2'd1, 8'h3C);
    push_wb(2'd2, 8'h30); push_ret(8'd2, 1'b1);
    issue(3'b010, 2'd2, 2'd0, 2'd1, 4'h0, 8'hF0, 8'h3C, 1'b0);
    push_wb(2'd0, 8'h3C); push_ret(8'd3, 1'b1);
    issue(3'b011, 2'd0, 2'd1, 2'd2, 4'h0, 8'h3C, 8'h30, 1'b0);
    push_wb(2'd1, 8'h0C); push_ret(8'd4, 1'b1);
    issue(3'b100, 2'd1, 2'd0, 2'd2, 4'h0, 8'h3C, 8'h30, 1'b0);
    push_wb(2'd2, 8'h18); push_ret(8'd5, 1'b1);
    issue(3'b000, 2'd2, 2'd1, 2'd1, 4'h0, 8'h0C, 8'h0C, 1'b0);

    // clr_ovf alone
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("clr_ovf", 32'(ovf_sticky), 32'd0);

    // beq taken with offset -2, then bne not taken
    ld(2'd1, 8'h11); ld(2'd2, 8'h11);
    push_ret(8'd3, 1'b0);
    issue(3'b110, 2'd0, 2'd1, 2'd2, 4'hE, 8'h11, 8'h11, 1'b0);
    push_ret(8'd4, 1'b0);
    issue(3'b111, 2'd0, 2'd1, 2'd2, 4'hE, 8'h11, 8'h11, 1'b0);

    // ld_en collides with instr_valid; clr_ovf during overflowing WB
    ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h7F;
    instr_valid = 1'b1; instr_op = 3'b000; instr_rd = 2'd1; instr_rs1 = 2'd0; instr_rs2 = 2'd0;
    #1;
    check("ld_blocks_ready", 32'(instr_ready), 32'd0);
    tick();
    ld_en = 1'b0;
    rd_addr = 2'd0; #1;
    check("ld_not_accepted", 32'(busy), 32'd0);
    check("ld_ready_back", 32'(instr_ready), 32'd1);
    check("ld_r0", 32'(rd_data), 32'h7F);
    push_wb(2'd1, 8'hFE); push_ret(8'd5, 1'b1);
    issue(3'b000, 2'd1, 2'd0, 2'd0, 4'h0, 8'h7F, 8'h7F, 1'b1);
    rd_addr = 2'd1; #1;
    check("rd_r1", 32'(rd_data), 32'hFE);

    // Reset during EXEC discards the instruction
    instr_valid = 1'b1; instr_op = 3'b000; instr_rd = 2'd3; instr_rs1 = 2'd1; instr_rs2 = 2'd1;
    tick();
    instr_valid = 1'b0;
    check("midrst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_idle", 32'(busy), 32'd0);
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_ovf", 32'(ovf_sticky), 32'd0);
    check("midrst_wb", 32'(wb_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      check("midrst_reg", 32'(rd_data), 32'd0);
    end
    tick();
    check("midrst_no_wb", 32'(wb_valid), 32'd0);

    // Taken branch from pc=0 with offset -1 wraps to 0xFF
    push_ret(8'hFF, 1'b0);
    issue(3'b110, 2'd0, 2'd0, 2'd0, 4'hF, 8'h00, 8'h00, 1'b0);

    repeat (4) tick();
`ifdef SEQ_RETIRE_CNT_EN
    check("retire_cnt", 32'(retire_cnt), 32'd1);
`endif
    check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    check("ret_queue_drained", 32'(ret_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
- Control/operand stage directly upstream of the 8-bit combinational ALU.
- Accepts one instruction per valid/ready handshake and reads operands from a 4-entry x 8-bit register file.
- Drives the ALU a/b/sel inputs, captures f/ovf/take_branch, then writes back the result or updates the PC.
- Multi-cycle, non-pipelined: one instruction retires every 3 cycles.

Parameters:
- PC_W, 8, program counter width; PC wraps modulo 2^PC_W.
- IMM_W, 4, signed branch offset width (two's complement, sign-extended to PC_W).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  sequencer can accept
- instr_op  in  3  ALU select code (000 add … 110 beq, 111 bne)
- instr_rd  in  2  destination register
- instr_rs1  in  2  source for ALU a
- instr_rs2  in  2  source for ALU b
- instr_imm  in  IMM_W  signed branch offset
- ld_en  in  1  external register load strobe
- ld_addr  in  2  load target
- ld_data  in  8  load value
- rd_addr  in  2  debug read address
- rd_data  out  8  combinational regs[rd_addr]
- alu_a  out  8  to ALU a
- alu_b  out  8  to ALU b
- alu_sel  out  3  to ALU sel
- alu_f  in  8  ALU result
- alu_ovf  in  1  ALU overflow
- alu_take_branch  in  1  ALU branch decision
- wb_valid  out  1  one-cycle pulse on register writeback
- wb_rd  out  2  written register
- wb_data  out  8  written value
- pc  out  PC_W  program counter
- ovf_sticky  out  1  sticky overflow flag
- clr_ovf  in  1  clear sticky flag
- busy  out  1  state != IDLE

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE; regs[0..3]=0; pc=0; ovf_sticky=0.
  - wb_valid=0, wb_rd=0, wb_data=0; internal op/rd/rs/imm/f/ovf/tb latches=0.
  - Reset mid-instruction discards that instruction; no writeback or PC change follows.
- FSM IDLE -> EXEC -> WB -> IDLE.
- IDLE:
  - instr_ready = ~ld_en. ld_en has priority: it writes regs[ld_addr]=ld_data and the instruction is not accepted that cycle.
  - On instr_valid & instr_ready: latch op, rd, rs1, rs2, imm; go to EXEC.
  - ld_en is ignored outside IDLE.
- EXEC (1 cycle):
  - alu_a=regs[rs1_q], alu_b=regs[rs2_q], alu_sel=op_q.
  - Register alu_f, alu_ovf, alu_take_branch at the end of the cycle; go to WB.
  - In all other states alu_a, alu_b and alu_sel are driven to 0.
- WB (1 cycle):
  - op_q in 000..101: regs[rd_q]=f_q; wb_valid=1, wb_rd=rd_q, wb_data=f_q (registered outputs, valid during the WB cycle); pc=pc+1.
  - op_q 110/111: no register write, wb_valid=0, f_q ignored; pc = tb_q ? pc+sext(imm_q) : pc+1.
  - op_q 000 and ovf_q=1: ovf_sticky=1. ovf is ignored for all other ops.
  - Go to IDLE.
- Timing:
  - Accept at edge T; wb_valid high in cycle T+2; next accept possible at T+3.
  - instr_ready=0 in EXEC and WB.
- Hazards: a new instruction always reads register values that include the prior writeback (no hazards).
- PC arithmetic is modulo 2^PC_W, e.g. pc=0 with imm=-1 gives 2^PC_W-1.
- clr_ovf and a set event in the same cycle: set wins. clr_ovf alone clears ovf_sticky next edge.
- wb_valid deasserts in every cycle other than WB.

Optional Feature:
- Macro: SEQ_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt[15:0], reset to 0.
  - Increments once per WB cycle (writebacks and branches); wraps 0xFFFF->0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- ld r1=0x70, r2=0x20; op=000 rd=3 rs1=1 rs2=2 -> EXEC alu_a=0x70, alu_b=0x20, alu_sel=000; WB wb_valid=1, wb_rd=3, wb_data=0x90; ovf_sticky=1; pc=1; rd_addr=3 -> rd_data=0x90.
- ld r0=0xF0, r1=0x3C; op=010 rd=2 rs1=0 rs2=1 -> wb_data=0x30; ovf_sticky unchanged; instr_ready=0 for exactly 2 cycles after accept.
- pc=5, r1=r2=0x11, op=110 rs1=1 rs2=2 imm=4'hE -> ALU returns take_branch=1; pc=3; wb_valid stays 0. Same with op=111 (take_branch=0) -> pc=6.
- pc=0, branch taken with imm=4'hF -> pc=0xFF (PC_W=8 wrap).
- Accept op=000, assert rst during the EXEC cycle -> next cycle state IDLE, regs=0, pc=0, ovf_sticky=0, no wb_valid pulse.
- ld_en=1 and instr_valid=1 in IDLE -> instr_ready=0, regs[ld_addr] loaded, instruction accepted on the following cycle once ld_en=0. clr_ovf asserted in the same WB cycle as an overflow -> ovf_sticky=1.
